pcpi_dispatch: RTL and testbench
================================

PCPI_DISPATCH -- requirements
Module: pcpi_dispatch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL set the cycles in BUSY without cp_ready before abort; legal range 2..255.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 resetn  in  1  reset, synchronous and active-low.
REQ-004 pcpi_valid  in  1  core request valid.
REQ-005 pcpi_insn  in  32  core instruction.
REQ-006 pcpi_rs1, pcpi_rs2  in  32 each  core operands.
REQ-007 pcpi_wr  out  1  result-write enable to core.
REQ-008 pcpi_rd  out  32  result to core.
REQ-009 pcpi_wait  out  1  request claimed, in progress.
REQ-010 pcpi_ready  out  1  one-cycle completion strobe to core.
REQ-011 cp_valid  out  2  per-coprocessor request; bit0 = M unit, bit1 = custom unit.
REQ-012 cp_insn, cp_rs1, cp_rs2  out  32 each  registered request shared by both units.
REQ-013 cp_ready, cp_wr, cp_busy  in  2 each  per-unit response.
REQ-014 cp_rd0, cp_rd1  in  32 each  per-unit result.
REQ-015 timeout_err  out  1  one-cycle pulse on abort.

Function
REQ-016 Decode SHALL be: port 0 if insn[6:0]=0110011 and insn[31:25]=0000001; port 1 if insn[6:0]=0001011; else unclaimed.
REQ-017 States SHALL be IDLE, BUSY, RESP, DRAIN; all outputs registered.
REQ-018 IDLE: pcpi_valid=1 and claimed -> latch insn/rs1/rs2 into cp_* and port index sel; go BUSY next cycle.
REQ-019 IDLE: unclaimed or pcpi_valid=0 -> stay IDLE, no output change (core's own timeout traps).
REQ-020 BUSY: cp_valid[sel]=1, cp_valid[~sel]=0, pcpi_wait=1; cp_insn/rs1/rs2 held constant for the whole of BUSY.
REQ-021 BUSY with cp_ready[sel]=1 -> capture cp_wr[sel] and selected cp_rd; go RESP.
REQ-022 cp_ready/cp_wr/cp_rd of the non-selected port SHALL be ignored in every state.
REQ-023 RESP: pcpi_ready=1 exactly one cycle, pcpi_wr/pcpi_rd = captured values, cp_valid=0, pcpi_wait=0; go DRAIN.
REQ-024 DRAIN: all strobes 0; stay until pcpi_valid=0, then IDLE; no request is accepted from DRAIN.
REQ-025 Latency: pcpi_valid sampled in IDLE at edge N -> cp_valid high from N+1; cp_ready sampled at edge M -> pcpi_ready high in cycle M+1.
REQ-026 8-bit cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle; no wrap in legal range.
REQ-027 Counter = TIMEOUT_CYCLES-1 without cp_ready[sel] -> go RESP with pcpi_wr=0, pcpi_rd=0; timeout_err=1 in that RESP cycle.
REQ-028 cp_ready[sel] in the same cycle as timeout -> ready wins; normal response, no timeout_err.
REQ-029 pcpi_valid=0 while in BUSY -> abort to IDLE next cycle: cp_valid=0, no pcpi_ready, no timeout_err.
REQ-030 pcpi_wr and pcpi_rd SHALL be 0 in every state except RESP.
REQ-031 cp_busy SHALL be observational only, not affecting state.

Reset
REQ-032 resetn=0 at an edge -> state IDLE, counter 0, sel 0, cp_insn/cp_rs1/cp_rs2 0; all 1-bit outputs and pcpi_rd 0; cp_valid 00. Applies from any state, including mid-BUSY.
REQ-033 No request SHALL be accepted in the cycle resetn is low.

Verification
REQ-034 MUL (insn 0x02B50533), rs1=7, rs2=6, M unit real -> cp_valid=01 one cycle after issue; pcpi_ready one cycle after cp_ready; pcpi_wr=1, pcpi_rd=0x0000002A.
REQ-035 DIVU rs1=0x10, rs2=0 -> pcpi_rd=0xFFFFFFFF, pcpi_wr=1; cp_rs1/cp_rs2 stable throughout BUSY.
REQ-036 Custom opcode 0x0000000B, stub ready after 3 cycles with rd=0x12345678 while port 0 drives cp_ready=1 -> cp_valid=10; port 0 ignored; pcpi_rd=0x12345678.
REQ-037 Stub never readies, TIMEOUT_CYCLES=64 -> pcpi_ready and timeout_err in cycle 65 after issue, pcpi_wr=0, pcpi_rd=0; ready at cycle 64 instead -> normal response, no error.
REQ-038 Unclaimed opcode 0x00000013 held 20 cycles -> cp_valid=00, pcpi_wait=0, pcpi_ready=0 throughout.
REQ-039 resetn=0 for 1 cycle mid-BUSY -> all outputs 0 next cycle; pcpi_valid held afterwards -> re-issued from IDLE, correct result.

Source files
------------

// File: rtl/pcpi_dispatch.sv
// PCPI request dispatcher: claims M-extension and custom-0 instructions from the core,
// forwards them to one of two coprocessor ports, and returns the result with a busy timeout.
module pcpi_dispatch #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic [1:0]  cp_valid,
    output logic [31:0] cp_insn,
    output logic [31:0] cp_rs1,
    output logic [31:0] cp_rs2,
    input  logic [1:0]  cp_ready,
    input  logic [1:0]  cp_wr,
    input  logic [1:0]  cp_busy,
    input  logic [31:0] cp_rd0,
    input  logic [31:0] cp_rd1,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic        sel, sel_n;
    logic [7:0]  count, count_n;
    logic [31:0] insn_n, rs1_n, rs2_n;
    logic [1:0]  cp_valid_n;
    logic        wait_n, ready_n, wr_n, terr_n;
    logic [31:0] rd_n;

    logic claim_m, claim_custom;
    logic sel_ready, sel_wr;
    logic [31:0] sel_rd;

    // cp_busy is informational only; it never steers the dispatcher.
    logic unused_busy;
    assign unused_busy = ^cp_busy;

    assign claim_m      = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
    assign claim_custom = (pcpi_insn[6:0] == 7'b0001011);

    assign sel_ready = sel ? cp_ready[1] : cp_ready[0];
    assign sel_wr    = sel ? cp_wr[1]    : cp_wr[0];
    assign sel_rd    = sel ? cp_rd1      : cp_rd0;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_n    = state;
        sel_n      = sel;
        count_n    = count;
        insn_n     = cp_insn;
        rs1_n      = cp_rs1;
        rs2_n      = cp_rs2;
        cp_valid_n = 2'b00;
        wait_n     = 1'b0;
        ready_n    = 1'b0;
        wr_n       = 1'b0;
        rd_n       = 32'd0;
        terr_n     = 1'b0;

        unique case (state)
            IDLE: begin
                if (pcpi_valid && (claim_m || claim_custom)) begin
                    state_n    = BUSY;
                    sel_n      = claim_custom;
                    count_n    = 8'd0;
                    insn_n     = pcpi_insn;
                    rs1_n      = pcpi_rs1;
                    rs2_n      = pcpi_rs2;
                    cp_valid_n = claim_custom ? 2'b10 : 2'b01;
                    wait_n     = 1'b1;
                end
            end
            BUSY: begin
                if (!pcpi_valid) begin
                    state_n = IDLE;
                end else if (sel_ready) begin
                    state_n = RESP;
                    ready_n = 1'b1;
                    wr_n    = sel_wr;
                    rd_n    = sel_rd;
                end else if (count == LAST_COUNT) begin
                    state_n = RESP;
                    ready_n = 1'b1;
                    terr_n  = 1'b1;
                end else begin
                    count_n    = count + 8'd1;
                    cp_valid_n = sel ? 2'b10 : 2'b01;
                    wait_n     = 1'b1;
                end
            end
            RESP: begin
                state_n = DRAIN;
            end
            DRAIN: begin
                // The core must drop pcpi_valid before a new request can be claimed.
                if (!pcpi_valid) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            sel         <= 1'b0;
            count       <= 8'd0;
            cp_insn     <= 32'd0;
            cp_rs1      <= 32'd0;
            cp_rs2      <= 32'd0;
            cp_valid    <= 2'b00;
            pcpi_wait   <= 1'b0;
            pcpi_ready  <= 1'b0;
            pcpi_wr     <= 1'b0;
            pcpi_rd     <= 32'd0;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state       <= state_n;
            sel         <= sel_n;
            count       <= count_n;
            cp_insn     <= insn_n;
            cp_rs1      <= rs1_n;
            cp_rs2      <= rs2_n;
            cp_valid    <= cp_valid_n;
            pcpi_wait   <= wait_n;
            pcpi_ready  <= ready_n;
            pcpi_wr     <= wr_n;
            pcpi_rd     <= rd_n;
            timeout_err <= terr_n;
        end
    end

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Directed bench for pcpi_dispatch: each task drives one scenario and checks outputs
// one time unit after the rising edge against hand-computed values.
module tb_pcpi_dispatch;

    localparam logic [31:0] INSN_MUL  = 32'h02B50533;
    localparam logic [31:0] INSN_DIVU = 32'h02B55533;
    localparam logic [31:0] INSN_CUST = 32'h0000000B;
    localparam logic [31:0] INSN_ADDI = 32'h00000013;
    localparam logic [31:0] INSN_ADD  = 32'h00B50533;

    // Expected {cp_valid, pcpi_wait, pcpi_ready, pcpi_wr, timeout_err}
    localparam logic [5:0] ST_IDLE  = 6'b000000;
    localparam logic [5:0] ST_BUSY0 = 6'b011000;
    localparam logic [5:0] ST_BUSY1 = 6'b101000;
    localparam logic [5:0] ST_RESPW = 6'b000110;
    localparam logic [5:0] ST_RESPT = 6'b000101;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr, pcpi_wait, pcpi_ready, timeout_err;
    logic [31:0] pcpi_rd;
    logic [1:0]  cp_valid, cp_ready, cp_wr, cp_busy;
    logic [31:0] cp_insn, cp_rs1, cp_rs2, cp_rd0, cp_rd1;
    logic [5:0]  strobes;

    int n_checks = 0;
    int n_fail   = 0;

    assign strobes = {cp_valid, pcpi_wait, pcpi_ready, pcpi_wr, timeout_err};

    pcpi_dispatch #(.TIMEOUT_CYCLES(64)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pcpi_valid  (pcpi_valid),
        .pcpi_insn   (pcpi_insn),
        .pcpi_rs1    (pcpi_rs1),
        .pcpi_rs2    (pcpi_rs2),
        .pcpi_wr     (pcpi_wr),
        .pcpi_rd     (pcpi_rd),
        .pcpi_wait   (pcpi_wait),
        .pcpi_ready  (pcpi_ready),
        .cp_valid    (cp_valid),
        .cp_insn     (cp_insn),
        .cp_rs1      (cp_rs1),
        .cp_rs2      (cp_rs2),
        .cp_ready    (cp_ready),
        .cp_wr       (cp_wr),
        .cp_busy     (cp_busy),
        .cp_rd0      (cp_rd0),
        .cp_rd1      (cp_rd1),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
        pcpi_valid = 1'b1;
        pcpi_insn  = insn;
        pcpi_rs1   = rs1;
        pcpi_rs2   = rs2;
        tick();
    endtask

    // Clear unit responses, drop the request and walk RESP -> DRAIN -> IDLE.
    task automatic finish_txn();
        cp_ready   = 2'b00;
        cp_wr      = 2'b00;
        cp_rd0     = 32'd0;
        cp_rd1     = 32'd0;
        pcpi_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        pcpi_valid = 1'b1;
        pcpi_insn  = INSN_MUL;
        pcpi_rs1   = 32'd7;
        pcpi_rs2   = 32'd6;
        tick();
        tick();
        n_checks++;
        if (strobes !== ST_IDLE) begin
            n_fail++; $display("FAIL reset_strobes: got %b want %b", strobes, ST_IDLE);
        end
        n_checks++;
        if ({cp_insn, cp_rs1, cp_rs2, pcpi_rd} !== 128'd0) begin
            n_fail++; $display("FAIL reset_data: insn=%h rs1=%h rs2=%h rd=%h want all 0", cp_insn, cp_rs1, cp_rs2, pcpi_rd);
        end
        pcpi_valid = 1'b0;
        resetn     = 1'b1;
        tick();
    endtask

    task automatic test_mul();
        logic [31:0] exp_rd;
        exp_rd = 32'd7 * 32'd6;
        issue(INSN_MUL, 32'd7, 32'd6);
        n_checks++;
        if (strobes !== ST_BUSY0) begin
            n_fail++; $display("FAIL mul_busy: got %b want %b", strobes, ST_BUSY0);
        end
        n_checks++;
        if ({cp_insn, cp_rs1, cp_rs2} !== {INSN_MUL, 32'd7, 32'd6}) begin
            n_fail++; $display("FAIL mul_operands: got %h %h %h want %h 7 6", cp_insn, cp_rs1, cp_rs2, INSN_MUL);
        end
        cp_ready = 2'b01;
        cp_wr    = 2'b01;
        cp_rd0   = exp_rd;
        tick();
        n_checks++;
        if (strobes !== ST_RESPW || pcpi_rd !== 32'h0000002A) begin
            n_fail++; $display("FAIL mul_resp: got %b rd=%h want %b rd=0000002a", strobes, pcpi_rd, ST_RESPW);
        end
        cp_ready = 2'b00;
        cp_wr    = 2'b00;
        cp_rd0   = 32'd0;
        tick();
        n_checks++;
        if (strobes !== ST_IDLE || pcpi_rd !== 32'd0) begin
            n_fail++; $display("FAIL mul_drain: got %b rd=%h want %b rd=0", strobes, pcpi_rd, ST_IDLE);
        end
        tick();
        n_checks++;
        if (strobes !== ST_IDLE) begin
            n_fail++; $display("FAIL mul_drain_no_accept: got %b want %b", strobes, ST_IDLE);
        end
        pcpi_valid = 1'b0;
        tick();
        n_checks++;
        if (strobes !== ST_IDLE) begin
            n_fail++; $display("FAIL mul_back_idle: got %b want %b", strobes, ST_IDLE);
        end
    endtask

    task automatic test_divu();
        issue(INSN_DIVU, 32'h10, 32'h0);
        pcpi_rs1 = 32'hA5A5A5A5;
        pcpi_rs2 = 32'h5A5A5A5A;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (strobes !== ST_BUSY0 || cp_rs1 !== 32'h10 || cp_rs2 !== 32'h0 || cp_insn !== INSN_DIVU) begin
                n_fail++; $display("FAIL divu_hold[%0d]: got %b rs1=%h rs2=%h want %b rs1=10 rs2=0", k, strobes, cp_rs1, cp_rs2, ST_BUSY0);
            end
            tick();
        end
        cp_ready = 2'b01;
        cp_wr    = 2'b01;
        cp_rd0   = 32'hFFFFFFFF;
        tick();
        n_checks++;
        if (strobes !== ST_RESPW || pcpi_rd !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL divu_resp: got %b rd=%h want %b rd=ffffffff", strobes, pcpi_rd, ST_RESPW);
        end
        finish_txn();
    endtask

    task automatic test_custom();
        cp_ready = 2'b01;
        cp_wr    = 2'b01;
        cp_rd0   = 32'hDEADBEEF;
        issue(INSN_CUST, 32'd1, 32'd2);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (strobes !== ST_BUSY1) begin
                n_fail++; $display("FAIL custom_busy[%0d]: got %b want %b", k, strobes, ST_BUSY1);
            end
            if (k < 2) tick();
        end
        cp_ready = 2'b11;
        cp_wr    = 2'b11;
        cp_rd1   = 32'h12345678;
        tick();
        n_checks++;
        if (strobes !== ST_RESPW || pcpi_rd !== 32'h12345678) begin
            n_fail++; $display("FAIL custom_resp: got %b rd=%h want %b rd=12345678", strobes, pcpi_rd, ST_RESPW);
        end
        finish_txn();
    endtask

    task automatic test_timeout();
        int busy_bad;
        busy_bad = 0;
        cp_wr  = 2'b10;
        cp_rd1 = 32'hBAADF00D;
        issue(INSN_CUST, 32'd3, 32'd4);
        for (int k = 1; k <= 63; k++) begin
            tick();
            if (strobes !== ST_BUSY1) busy_bad++;
        end
        n_checks++;
        if (busy_bad != 0) begin
            n_fail++; $display("FAIL timeout_busy_window: got %0d off-busy cycles want 0", busy_bad);
        end
        tick();
        n_checks++;
        if (strobes !== ST_RESPT || pcpi_rd !== 32'd0) begin
            n_fail++; $display("FAIL timeout_resp: got %b rd=%h want %b rd=0", strobes, pcpi_rd, ST_RESPT);
        end
        tick();
        n_checks++;
        if (strobes !== ST_IDLE) begin
            n_fail++; $display("FAIL timeout_pulse_width: got %b want %b", strobes, ST_IDLE);
        end
        finish_txn();
    endtask

    task automatic test_ready_at_limit();
        int busy_bad;
        busy_bad = 0;
        issue(INSN_CUST, 32'd5, 32'd6);
        for (int k = 1; k <= 63; k++) begin
            tick();
            if (strobes !== ST_BUSY1) busy_bad++;
        end
        n_checks++;
        if (busy_bad != 0) begin
            n_fail++; $display("FAIL limit_busy_window: got %0d off-busy cycles want 0", busy_bad);
        end
        cp_ready = 2'b10;
        cp_wr    = 2'b10;
        cp_rd1   = 32'hCAFEF00D;
        tick();
        n_checks++;
        if (strobes !== ST_RESPW || pcpi_rd !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL limit_ready_wins: got %b rd=%h want %b rd=cafef00d", strobes, pcpi_rd, ST_RESPW);
        end
        finish_txn();
    endtask

    task automatic test_unclaimed();
        int bad;
        bad = 0;
        pcpi_valid = 1'b1;
        pcpi_insn  = INSN_ADDI;
        repeat (20) begin
            tick();
            if (strobes !== ST_IDLE) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL unclaimed_addi: got %0d active cycles want 0", bad);
        end
        bad = 0;
        pcpi_insn = INSN_ADD;
        repeat (3) begin
            tick();
            if (strobes !== ST_IDLE) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL unclaimed_add: got %0d active cycles want 0", bad);
        end
        bad = 0;
        pcpi_valid = 1'b0;
        pcpi_insn  = INSN_MUL;
        repeat (3) begin
            tick();
            if (strobes !== ST_IDLE) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL no_valid: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_abort();
        issue(INSN_MUL, 32'd9, 32'd9);
        tick();
        pcpi_valid = 1'b0;
        cp_ready   = 2'b00;
        tick();
        n_checks++;
        if (strobes !== ST_IDLE) begin
            n_fail++; $display("FAIL abort_release: got %b want %b", strobes, ST_IDLE);
        end
        tick();
        n_checks++;
        if (strobes !== ST_IDLE) begin
            n_fail++; $display("FAIL abort_stays_idle: got %b want %b", strobes, ST_IDLE);
        end
    endtask

    task automatic test_reset_mid_busy();
        issue(INSN_MUL, 32'd3, 32'd5);
        tick();
        resetn = 1'b0;
        tick();
        n_checks++;
        if (strobes !== ST_IDLE || {cp_insn, cp_rs1, cp_rs2, pcpi_rd} !== 128'd0) begin
            n_fail++; $display("FAIL midreset_clear: got %b insn=%h rs1=%h rd=%h want all 0", strobes, cp_insn, cp_rs1, pcpi_rd);
        end
        resetn = 1'b1;
        tick();
        n_checks++;
        if (strobes !== ST_BUSY0 || cp_rs1 !== 32'd3 || cp_rs2 !== 32'd5) begin
            n_fail++; $display("FAIL midreset_reissue: got %b rs1=%h rs2=%h want %b 3 5", strobes, cp_rs1, cp_rs2, ST_BUSY0);
        end
        cp_ready = 2'b01;
        cp_wr    = 2'b01;
        cp_rd0   = 32'd15;
        tick();
        n_checks++;
        if (strobes !== ST_RESPW || pcpi_rd !== 32'd15) begin
            n_fail++; $display("FAIL midreset_result: got %b rd=%h want %b rd=f", strobes, pcpi_rd, ST_RESPW);
        end
        finish_txn();
    endtask

    task automatic test_back_to_back();
        cp_busy = 2'b11;
        issue(INSN_CUST, 32'd0, 32'd0);
        cp_ready = 2'b10;
        cp_wr    = 2'b00;
        cp_rd1   = 32'h00000001;
        tick();
        n_checks++;
        if (strobes !== 6'b000100 || pcpi_rd !== 32'h00000001) begin
            n_fail++; $display("FAIL b2b_first: got %b rd=%h want 000100 rd=1", strobes, pcpi_rd);
        end
        finish_txn();
        cp_busy = 2'b01;
        issue(INSN_MUL, 32'hFFFFFFFF, 32'd2);
        n_checks++;
        if (strobes !== ST_BUSY0) begin
            n_fail++; $display("FAIL b2b_second_issue: got %b want %b", strobes, ST_BUSY0);
        end
        cp_ready = 2'b01;
        cp_wr    = 2'b01;
        cp_rd0   = 32'hFFFFFFFE;
        tick();
        n_checks++;
        if (strobes !== ST_RESPW || pcpi_rd !== 32'hFFFFFFFE) begin
            n_fail++; $display("FAIL b2b_second_resp: got %b rd=%h want %b rd=fffffffe", strobes, pcpi_rd, ST_RESPW);
        end
        finish_txn();
        cp_busy = 2'b00;
    endtask

    initial begin
        resetn     = 1'b0;
        pcpi_valid = 1'b0;
        pcpi_insn  = 32'd0;
        pcpi_rs1   = 32'd0;
        pcpi_rs2   = 32'd0;
        cp_ready   = 2'b00;
        cp_wr      = 2'b00;
        cp_busy    = 2'b00;
        cp_rd0     = 32'd0;
        cp_rd1     = 32'd0;

        test_reset();
        test_mul();
        test_divu();
        test_custom();
        test_timeout();
        test_ready_at_limit();
        test_unclaimed();
        test_abort();
        test_reset_mid_busy();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
